tensor_core_instruction_sequencer: RTL and testbench
====================================================

Name: tensor_core_instruction_sequencer

Overview:
Single-clock program sequencer that drives the tensor core from program memory and data memory. It fetches 64-bit machine-code words and decodes the 2-bit opcode. Each instruction is issued as a one-cycle 16-bit tensor-core instruction; burst-write operands are gathered from data memory and burst-read results are written back. It sits between the program/data SRAMs and the tensor core controller, and replaces dual-edge instruction stepping with an explicit FSM.

Parameters:
ADDR_WIDTH, 16, program and data memory address width
DATA_WIDTH, 8, data memory word and tensor core output width

Ports:
clock_in  input  1  system clock
reset_in  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins execution; ignored unless IDLE
start_address  input  ADDR_WIDTH  first program word address, sampled on start
instruction_count  input  ADDR_WIDTH  number of instructions to execute, sampled on start
prog_rd_en  output  1  program memory read strobe
prog_addr  output  ADDR_WIDTH  program memory address
prog_rdata  input  64  program word, valid 1 cycle after prog_rd_en
data_rd_en  output  1  data memory dual-read strobe
data_rd_addr1  output  ADDR_WIDTH  operand A address = word[31:16]
data_rd_addr2  output  ADDR_WIDTH  operand B address = word[47:32]
data_rdata1  input  DATA_WIDTH  operand A, valid 1 cycle after data_rd_en
data_rdata2  input  DATA_WIDTH  operand B, valid 1 cycle after data_rd_en
data_wr_en  output  1  data memory write strobe
data_wr_addr  output  ADDR_WIDTH  write address = word[63:48]
data_wr_data  output  DATA_WIDTH  tensor core output captured for write-back
tensor_core_controller_output  input  DATA_WIDTH  signed tensor core result, combinational from the issued instruction
current_tensor_core_instruction  output  16  instruction to the tensor core
tensor_core_reset_out  output  1  tensor core reset
busy  output  1  high outside IDLE
done  output  1  one-cycle pulse after the last instruction

Behaviour:
- Reset (async): state=IDLE; pc, counters and instruction register = 0. All outputs are 0 except tensor_core_reset_out=1 while reset_in is asserted.
- Decode fields: opcode=word[1:0] (00 NOP, 01 OPERATE, 10 BURST, 11 RESET); burst_sel=word[3:2] (00 READ, 01 WRITE, 10 READ_AND_WRITE, 11 reserved).
- Burst flags: wr_act = BURST && sel in {01,10} && word[15]. rd_act = BURST && sel in {00,10} && word[14].
- FSM states: IDLE, FETCH, DECODE, OPERAND, ISSUE, DONE.
- IDLE: on start, load pc=start_address and remaining=instruction_count. Go to DONE if instruction_count==0, else FETCH.
- FETCH: prog_rd_en=1, prog_addr=pc; go to DECODE.
- DECODE: register prog_rdata into instr. If wr_act, data_rd_en=1 with both operand addresses and go to OPERAND; else go to ISSUE.
- OPERAND: register {data_rdata1, data_rdata2} as the 16-bit operand; go to ISSUE.
- ISSUE lasts exactly one cycle. current_tensor_core_instruction is selected in priority order:
  - RESET: 0, with tensor_core_reset_out=1;
  - wr_act: {operand A, operand B};
  - rd_act: 0;
  - reserved burst select: 0;
  - otherwise (NOP, OPERATE, BURST with flags clear): instr[15:0].
- ISSUE write-back: if rd_act, data_wr_en=1, data_wr_addr=instr[63:48], data_wr_data=tensor_core_controller_output. READ_AND_WRITE with both flags set issues operands and writes back in the same cycle.
- ISSUE exit: pc+=1 (wraps modulo 2^ADDR_WIDTH), remaining-=1. Go to DONE if remaining becomes 0, else FETCH.
- DONE: done=1 for one cycle; go to IDLE.
- Latency per instruction: 3 cycles, or 4 with wr_act. Program of N instructions: done asserts 3N+(wr_act count)+1 cycles after start.
- current_tensor_core_instruction is 0 in every state except ISSUE. tensor_core_reset_out = reset_in || (ISSUE && RESET).
- start while busy: ignored.
- reset_in mid-operation: immediate return to IDLE; no done pulse; any in-flight write strobe is dropped.

Decomposition:
- Package tensor_core_isa_pkg: opcode and burst-select constants, field bit positions (opcode, burst_sel, write/read flag bits, address fields), sequencer state enum.
- Sub-module tensor_core_instruction_decoder: combinational 64-bit word -> opcode, wr_act, rd_act, three addresses, reserved flag.
- The FSM, counters and output muxing stay in the top module.

Test Plan:
- Reset: reset_in=1 for 2 cycles -> busy=0, done=0, instruction=0, tensor_core_reset_out=1; after release tensor_core_reset_out=0.
- OPERATE 64'h0000_0000_0000_1235, count=1, start_address=5 -> prog_addr=5; instruction 16'h1235 for exactly 1 cycle; done at cycle 4 after start.
- BURST write 64'h0000_0003_0002_8006, data[2]=8'hA1, data[3]=8'h5C -> data_rd_addr1=2, data_rd_addr2=3; instruction=16'hA15C for 1 cycle; no data_wr_en.
- BURST read 64'h0007_0000_0000_4002, controller output -8 -> instruction 0; data_wr_en=1, data_wr_addr=7, data_wr_data=8'hF8.
- RESET word 64'h3 between two OPERATEs, count=3 -> tensor_core_reset_out high for exactly the middle ISSUE cycle; done after 10 cycles. Run with start_address=16'hFFFF, count=2 -> second fetch at address 0.
- count=0 -> done one cycle after start, no prog_rd_en. reset_in mid-OPERAND -> IDLE, no done. start while busy -> no restart.

Source files
------------

// File: rtl/tensor_core_isa_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tensor_core_isa_pkg
// Purpose  : Tensor-core program word encoding (opcodes, burst selects, field
//            positions) and the sequencer state type.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package tensor_core_isa_pkg;

   // Opcode values carried in the two least significant bits of a word
   localparam logic [1:0] OP_NOP     = 2'b00;
   localparam logic [1:0] OP_OPERATE = 2'b01;
   localparam logic [1:0] OP_BURST   = 2'b10;
   localparam logic [1:0] OP_RESET   = 2'b11;

   // Burst sub-operation selects
   localparam logic [1:0] BSEL_READ       = 2'b00;
   localparam logic [1:0] BSEL_WRITE      = 2'b01;
   localparam logic [1:0] BSEL_READ_WRITE = 2'b10;
   localparam logic [1:0] BSEL_RESERVED   = 2'b11;

   // Field positions inside the 64-bit program word
   localparam int WORD_W       = 64;
   localparam int TC_INSTR_W   = 16;
   localparam int OPCODE_LSB   = 0;
   localparam int BSEL_LSB     = 2;
   localparam int RD_FLAG_BIT  = 14;
   localparam int WR_FLAG_BIT  = 15;
   localparam int ADDR1_LSB    = 16;
   localparam int ADDR2_LSB    = 32;
   localparam int WR_ADDR_LSB  = 48;
   localparam int ADDR_FIELD_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_DECODE  = 3'd2,
      ST_OPERAND = 3'd3,
      ST_ISSUE   = 3'd4,
      ST_DONE    = 3'd5
   } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/tensor_core_instruction_decoder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tensor_core_instruction_decoder
// Purpose  : Combinational split of a 64-bit program word into opcode, burst
//            activity flags, the three memory addresses and a reserved flag.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tensor_core_instruction_decoder
   import tensor_core_isa_pkg::*;
#(
   parameter int ADDR_WIDTH = 16
) (
   input  logic [WORD_W-1:0]     word,
   output logic [1:0]            opcode,
   output logic                  wr_act,
   output logic                  rd_act,
   output logic [ADDR_WIDTH-1:0] rd_addr1,
   output logic [ADDR_WIDTH-1:0] rd_addr2,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic                  reserved
);

   logic [1:0] bsel;
   logic       is_burst;

   // Bits between the burst select and the read flag carry no meaning here
   logic       unused_word_bits;
   assign unused_word_bits = ^word[RD_FLAG_BIT-1:BSEL_LSB+2];

   // Field extraction and burst flag qualification
   always_comb begin
      opcode   = word[OPCODE_LSB +: 2];
      bsel     = word[BSEL_LSB +: 2];
      is_burst = (opcode == OP_BURST);
      wr_act   = is_burst && ((bsel == BSEL_WRITE) || (bsel == BSEL_READ_WRITE))
                 && word[WR_FLAG_BIT];
      rd_act   = is_burst && ((bsel == BSEL_READ) || (bsel == BSEL_READ_WRITE))
                 && word[RD_FLAG_BIT];
      reserved = is_burst && (bsel == BSEL_RESERVED);
      rd_addr1 = ADDR_WIDTH'(word[ADDR1_LSB +: ADDR_FIELD_W]);
      rd_addr2 = ADDR_WIDTH'(word[ADDR2_LSB +: ADDR_FIELD_W]);
      wr_addr  = ADDR_WIDTH'(word[WR_ADDR_LSB +: ADDR_FIELD_W]);
   end

endmodule
`default_nettype wire

// File: rtl/tensor_core_instruction_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tensor_core_instruction_sequencer
// Purpose  : Fetches program words, gathers burst-write operands, issues one
//            16-bit tensor-core instruction per word and writes burst-read
//            results back to data memory.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tensor_core_instruction_sequencer
   import tensor_core_isa_pkg::*;
#(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clock_in,
   input  logic                  reset_in,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_address,
   input  logic [ADDR_WIDTH-1:0] instruction_count,
   output logic                  prog_rd_en,
   output logic [ADDR_WIDTH-1:0] prog_addr,
   input  logic [WORD_W-1:0]     prog_rdata,
   output logic                  data_rd_en,
   output logic [ADDR_WIDTH-1:0] data_rd_addr1,
   output logic [ADDR_WIDTH-1:0] data_rd_addr2,
   input  logic [DATA_WIDTH-1:0] data_rdata1,
   input  logic [DATA_WIDTH-1:0] data_rdata2,
   output logic                  data_wr_en,
   output logic [ADDR_WIDTH-1:0] data_wr_addr,
   output logic [DATA_WIDTH-1:0] data_wr_data,
   input  logic [DATA_WIDTH-1:0] tensor_core_controller_output,
   output logic [TC_INSTR_W-1:0] current_tensor_core_instruction,
   output logic                  tensor_core_reset_out,
   output logic                  busy,
   output logic                  done
);

   seq_state_t              state;
   seq_state_t              state_next;
   logic [ADDR_WIDTH-1:0]   pc;
   logic [ADDR_WIDTH-1:0]   remaining;
   logic [WORD_W-1:0]       instr;
   logic [2*DATA_WIDTH-1:0] operand;
   logic                    issue_reset;

   logic [WORD_W-1:0]       dec_word;
   logic [1:0]              dec_opcode;
   logic                    dec_wr_act;
   logic                    dec_rd_act;
   logic [ADDR_WIDTH-1:0]   dec_rd_addr1;
   logic [ADDR_WIDTH-1:0]   dec_rd_addr2;
   logic [ADDR_WIDTH-1:0]   dec_wr_addr;
   logic                    dec_reserved;

   // In DECODE the word is still on the memory bus and not yet in instr, so
   // the single decoder looks at the bus then and at instr otherwise.
   assign dec_word = (state == ST_DECODE) ? prog_rdata : instr;

   tensor_core_instruction_decoder #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_decoder (
      .word     (dec_word),
      .opcode   (dec_opcode),
      .wr_act   (dec_wr_act),
      .rd_act   (dec_rd_act),
      .rd_addr1 (dec_rd_addr1),
      .rd_addr2 (dec_rd_addr2),
      .wr_addr  (dec_wr_addr),
      .reserved (dec_reserved)
   );

   // State register
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Program counter, instruction countdown, instruction and operand capture
   always_ff @(posedge clock_in or posedge reset_in) begin
      if (reset_in) begin
         pc        <= '0;
         remaining <= '0;
         instr     <= '0;
         operand   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  pc        <= start_address;
                  remaining <= instruction_count;
               end
            end
            ST_DECODE:  instr   <= prog_rdata;
            ST_OPERAND: operand <= {data_rdata1, data_rdata2};
            ST_ISSUE: begin
               pc        <= pc + ADDR_WIDTH'(1);
               remaining <= remaining - ADDR_WIDTH'(1);
            end
            default: ;
         endcase
      end
   end

   // Next-state decision and all strobes; everything is quiet by default
   always_comb begin
      state_next                      = state;
      prog_rd_en                      = 1'b0;
      prog_addr                       = '0;
      data_rd_en                      = 1'b0;
      data_rd_addr1                   = '0;
      data_rd_addr2                   = '0;
      data_wr_en                      = 1'b0;
      data_wr_addr                    = '0;
      data_wr_data                    = '0;
      current_tensor_core_instruction = '0;
      issue_reset                     = 1'b0;
      done                            = 1'b0;
      busy                            = (state != ST_IDLE);

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = (instruction_count == '0) ? ST_DONE : ST_FETCH;
            end
         end
         ST_FETCH: begin
            prog_rd_en = 1'b1;
            prog_addr  = pc;
            state_next = ST_DECODE;
         end
         ST_DECODE: begin
            if (dec_wr_act) begin
               data_rd_en    = 1'b1;
               data_rd_addr1 = dec_rd_addr1;
               data_rd_addr2 = dec_rd_addr2;
               state_next    = ST_OPERAND;
            end else begin
               state_next = ST_ISSUE;
            end
         end
         ST_OPERAND: begin
            state_next = ST_ISSUE;
         end
         ST_ISSUE: begin
            if (dec_opcode == OP_RESET) begin
               issue_reset = 1'b1;
            end else if (dec_wr_act) begin
               current_tensor_core_instruction = TC_INSTR_W'(operand);
            end else if (dec_rd_act || dec_reserved) begin
               current_tensor_core_instruction = '0;
            end else begin
               current_tensor_core_instruction = instr[TC_INSTR_W-1:0];
            end
            // Write-back is independent of the issue priority so that
            // READ_AND_WRITE can issue operands and capture in one cycle.
            if (dec_rd_act) begin
               data_wr_en   = 1'b1;
               data_wr_addr = dec_wr_addr;
               data_wr_data = tensor_core_controller_output;
            end
            state_next = (remaining == ADDR_WIDTH'(1)) ? ST_DONE : ST_FETCH;
         end
         ST_DONE: begin
            done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // The core is held in reset with the sequencer and by RESET words
   assign tensor_core_reset_out = reset_in | issue_reset;

endmodule
`default_nettype wire

// File: tb/tb_tensor_core_instruction_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_tensor_core_instruction_sequencer
// Purpose  : Self-checking bench; memories and a toy tensor-core controller
//            surround the sequencer, and a program-level model predicts the
//            per-cycle bus activity.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_tensor_core_instruction_sequencer;

   logic        clk = 1'b0;
   logic        reset_in;
   logic        start;
   logic [15:0] start_address;
   logic [15:0] instruction_count;
   logic        prog_rd_en;
   logic [15:0] prog_addr;
   logic [63:0] prog_rdata;
   logic        data_rd_en;
   logic [15:0] data_rd_addr1;
   logic [15:0] data_rd_addr2;
   logic [7:0]  data_rdata1;
   logic [7:0]  data_rdata2;
   logic        data_wr_en;
   logic [15:0] data_wr_addr;
   logic [7:0]  data_wr_data;
   logic [7:0]  tc_out;
   logic [15:0] cur_instr;
   logic        tc_reset;
   logic        busy;
   logic        done;

   logic [7:0]  tc_bias;

   logic [63:0] prog_mem [0:65535];
   logic [7:0]  dmem     [0:65535];
   logic [7:0]  mdata    [0:65535];

   // Expected per-cycle activity, indexed by cycles after the start edge
   logic [15:0] e_instr  [0:63];
   logic        e_tcrst  [0:63];
   logic        e_prd    [0:63];
   logic [15:0] e_paddr  [0:63];
   logic        e_drd    [0:63];
   logic [15:0] e_a1     [0:63];
   logic [15:0] e_a2     [0:63];
   logic        e_dwr    [0:63];
   logic [15:0] e_waddr  [0:63];
   logic [7:0]  e_wdata  [0:63];
   int          e_done;

   int n_checks = 0;
   int n_fail   = 0;

   tensor_core_instruction_sequencer #(
      .ADDR_WIDTH (16),
      .DATA_WIDTH (8)
   ) dut (
      .clock_in                        (clk),
      .reset_in                        (reset_in),
      .start                           (start),
      .start_address                   (start_address),
      .instruction_count               (instruction_count),
      .prog_rd_en                      (prog_rd_en),
      .prog_addr                       (prog_addr),
      .prog_rdata                      (prog_rdata),
      .data_rd_en                      (data_rd_en),
      .data_rd_addr1                   (data_rd_addr1),
      .data_rd_addr2                   (data_rd_addr2),
      .data_rdata1                     (data_rdata1),
      .data_rdata2                     (data_rdata2),
      .data_wr_en                      (data_wr_en),
      .data_wr_addr                    (data_wr_addr),
      .data_wr_data                    (data_wr_data),
      .tensor_core_controller_output   (tc_out),
      .current_tensor_core_instruction (cur_instr),
      .tensor_core_reset_out           (tc_reset),
      .busy                            (busy),
      .done                            (done)
   );

   always #5 clk = ~clk;

   // Toy tensor-core controller: combinational function of the instruction
   function automatic logic [7:0] tc_model(input logic [15:0] i, input logic [7:0] b);
      return b ^ i[7:0] ^ i[15:8];
   endfunction
   assign tc_out = tc_model(cur_instr, tc_bias);

   // Synchronous program and data memories
   always @(posedge clk) begin
      if (prog_rd_en) prog_rdata <= prog_mem[prog_addr];
      if (data_rd_en) begin
         data_rdata1 <= dmem[data_rd_addr1];
         data_rdata2 <= dmem[data_rd_addr2];
      end
      if (data_wr_en) dmem[data_wr_addr] <= data_wr_data;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Program-level model: walk the program word by word and lay out the
   // resulting bus activity on a cycle timeline (3 cycles per word, one
   // more when operands must be fetched, then a done cycle).
   task automatic build_expect(input logic [15:0] sa, input logic [15:0] cnt);
      logic [15:0] pc;
      logic [63:0] w;
      logic [1:0]  op, sel;
      logic        burst, wr, rd;
      logic [15:0] opnd, issued;
      int          cyc, iss;
      for (int i = 0; i < 64; i++) begin
         e_instr[i] = '0; e_tcrst[i] = 1'b0; e_prd[i] = 1'b0; e_paddr[i] = '0;
         e_drd[i] = 1'b0; e_a1[i] = '0; e_a2[i] = '0;
         e_dwr[i] = 1'b0; e_waddr[i] = '0; e_wdata[i] = '0;
      end
      for (int a = 0; a < 65536; a++) mdata[a] = dmem[a];
      pc   = sa;
      cyc  = 1;
      opnd = '0;
      for (int k = 0; k < int'(cnt); k++) begin
         w     = prog_mem[pc];
         op    = w[1:0];
         sel   = w[3:2];
         burst = (op == 2'b10);
         wr    = burst && (sel == 2'b01 || sel == 2'b10) && w[15];
         rd    = burst && (sel == 2'b00 || sel == 2'b10) && w[14];
         e_prd[cyc]   = 1'b1;
         e_paddr[cyc] = pc;
         if (wr) begin
            e_drd[cyc+1] = 1'b1;
            e_a1[cyc+1]  = w[31:16];
            e_a2[cyc+1]  = w[47:32];
            opnd         = {mdata[w[31:16]], mdata[w[47:32]]};
            iss          = cyc + 3;
         end else begin
            iss          = cyc + 2;
         end
         if (op == 2'b11)                   issued = 16'h0;
         else if (wr)                       issued = opnd;
         else if (rd)                       issued = 16'h0;
         else if (burst && sel == 2'b11)    issued = 16'h0;
         else                               issued = w[15:0];
         e_instr[iss] = issued;
         e_tcrst[iss] = (op == 2'b11);
         if (rd) begin
            e_dwr[iss]   = 1'b1;
            e_waddr[iss] = w[63:48];
            e_wdata[iss] = tc_model(issued, tc_bias);
            mdata[w[63:48]] = tc_model(issued, tc_bias);
         end
         pc  = pc + 16'd1;
         cyc = iss + 1;
      end
      e_done = cyc;
   endtask

   // Start a program and compare every cycle through the done pulse plus one
   // idle cycle. With poke set, a second start is attempted while busy.
   task automatic run_program(input logic [15:0] sa, input logic [15:0] cnt, input bit poke);
      build_expect(sa, cnt);
      @(negedge clk);
      start             = 1'b1;
      start_address     = sa;
      instruction_count = cnt;
      for (int cyc = 1; cyc <= e_done + 1; cyc++) begin
         @(negedge clk);
         if (cyc == 1) start = 1'b0;
         check($sformatf("instr@%0d", cyc), 64'(cur_instr), 64'(e_instr[cyc]));
         check($sformatf("tc_reset@%0d", cyc), 64'(tc_reset), 64'(e_tcrst[cyc]));
         check($sformatf("prog_rd_en@%0d", cyc), 64'(prog_rd_en), 64'(e_prd[cyc]));
         if (e_prd[cyc]) check($sformatf("prog_addr@%0d", cyc), 64'(prog_addr), 64'(e_paddr[cyc]));
         check($sformatf("data_rd_en@%0d", cyc), 64'(data_rd_en), 64'(e_drd[cyc]));
         if (e_drd[cyc]) begin
            check($sformatf("rd_addr1@%0d", cyc), 64'(data_rd_addr1), 64'(e_a1[cyc]));
            check($sformatf("rd_addr2@%0d", cyc), 64'(data_rd_addr2), 64'(e_a2[cyc]));
         end
         check($sformatf("data_wr_en@%0d", cyc), 64'(data_wr_en), 64'(e_dwr[cyc]));
         if (e_dwr[cyc]) begin
            check($sformatf("wr_addr@%0d", cyc), 64'(data_wr_addr), 64'(e_waddr[cyc]));
            check($sformatf("wr_data@%0d", cyc), 64'(data_wr_data), 64'(e_wdata[cyc]));
         end
         check($sformatf("done@%0d", cyc), 64'(done), 64'(cyc == e_done));
         check($sformatf("busy@%0d", cyc), 64'(busy), 64'(cyc <= e_done));
         if (poke && cyc == 2) begin
            start             = 1'b1;
            start_address     = sa + 16'd100;
            instruction_count = 16'd5;
         end
         if (poke && cyc == 3) start = 1'b0;
      end
   endtask

   function automatic logic [63:0] rand_word();
      logic [63:0] w;
      w[63:48] = 16'($urandom_range(0, 15));
      w[47:32] = 16'($urandom_range(0, 15));
      w[31:16] = 16'($urandom_range(0, 15));
      w[15:0]  = 16'($urandom);
      return w;
   endfunction

   initial begin
      logic [15:0] sa;
      logic [15:0] cnt;
      reset_in          = 1'b1;
      start             = 1'b0;
      start_address     = '0;
      instruction_count = '0;
      tc_bias           = 8'h00;
      for (int a = 0; a < 65536; a++) begin
         prog_mem[a] = '0;
         dmem[a]     = 8'($urandom);
      end

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", 64'(busy), 64'h0);
      check("rst_done", 64'(done), 64'h0);
      check("rst_instr", 64'(cur_instr), 64'h0);
      check("rst_tc_reset", 64'(tc_reset), 64'h1);
      check("rst_prog_rd_en", 64'(prog_rd_en), 64'h0);
      check("rst_data_wr_en", 64'(data_wr_en), 64'h0);
      reset_in = 1'b0;
      #1;
      check("post_rst_tc_reset", 64'(tc_reset), 64'h0);

      // OPERATE
      prog_mem[5] = 64'h0000_0000_0000_1235;
      run_program(16'd5, 16'd1, 1'b0);

      // BURST write
      dmem[2] = 8'hA1;
      dmem[3] = 8'h5C;
      prog_mem[10] = 64'h0000_0003_0002_8006;
      run_program(16'd10, 16'd1, 1'b0);

      // BURST read with a controller output of -8
      tc_bias = 8'hF8;
      prog_mem[20] = 64'h0007_0000_0000_4002;
      run_program(16'd20, 16'd1, 1'b0);
      check("burst_read_mem", 64'(dmem[7]), 64'hF8);

      // RESET between two OPERATEs, with a start attempted while busy
      prog_mem[30] = 64'h0000_0000_0000_1235;
      prog_mem[31] = 64'h0000_0000_0000_0003;
      prog_mem[32] = 64'h0000_0000_0000_4321;
      run_program(16'd30, 16'd3, 1'b1);

      // Program counter wrap
      prog_mem[16'hFFFF] = 64'h0000_0000_0000_0005;
      prog_mem[0]        = 64'h0000_0000_0000_9AB1;
      run_program(16'hFFFF, 16'd2, 1'b0);

      // Empty program
      run_program(16'd40, 16'd0, 1'b0);

      // READ_AND_WRITE with both flags, then a reserved burst select
      tc_bias = 8'h3C;
      prog_mem[50] = 64'h0009_0004_0003_C00A;
      prog_mem[51] = 64'h0000_0000_0000_C00E;
      run_program(16'd50, 16'd2, 1'b0);

      // Reset while in OPERAND
      prog_mem[60] = 64'h0000_0003_0002_8006;
      @(negedge clk);
      start             = 1'b1;
      start_address     = 16'd60;
      instruction_count = 16'd1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_busy_before", 64'(busy), 64'h1);
      reset_in = 1'b1;
      #1;
      check("mid_busy", 64'(busy), 64'h0);
      check("mid_tc_reset", 64'(tc_reset), 64'h1);
      check("mid_instr", 64'(cur_instr), 64'h0);
      @(negedge clk);
      reset_in = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check($sformatf("mid_no_done%0d", i), 64'(done), 64'h0);
         check($sformatf("mid_idle%0d", i), 64'(busy), 64'h0);
      end

      // Random programs
      for (int r = 0; r < 20; r++) begin
         sa      = 16'($urandom);
         cnt     = 16'($urandom_range(1, 8));
         tc_bias = 8'($urandom);
         for (int k = 0; k < int'(cnt); k++) prog_mem[sa + 16'(k)] = rand_word();
         run_program(sa, cnt, r[0]);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
